pellet_map: RTL and testbench

PELLET_MAP -- requirements
Module: pellet_map

---
 rtl/pellet_map_pkg.sv | 37 +++
 rtl/pellet_layout_rom.sv | 18 +
 rtl/pellet_map.sv | 102 ++++++++++
 tb/tb_pellet_map.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pellet_map_pkg.sv
// Shared definitions for the pellet map: geometry, FSM encoding, power-up cells
// and the layout constants that the ROM and the pellet total are built from.
package pellet_map_pkg;

  localparam int MAP_W = 32;
  localparam int MAP_H = 32;
  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_READY = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam logic [4:0] PWR_X0 = 5'd2;
  localparam logic [4:0] PWR_X1 = 5'd27;
  localparam logic [4:0] PWR_Y0 = 5'd4;
  localparam logic [4:0] PWR_Y1 = 5'd24;

  // Rows 4,8,..,28 are open corridors (columns 1..30); the other inner rows
  // only carry pellets in the side lanes (columns 1, 2, 27, 30).
  localparam logic [MAP_W-1:0] ROW_FULL  = 32'h7FFF_FFFE;
  localparam logic [MAP_W-1:0] ROW_SIDE  = 32'h4800_0006;
  localparam int               FULL_ROWS = 7;
  localparam int               SIDE_ROWS = 23;

  function automatic logic [5:0] popcount(input logic [MAP_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAP_W; i++) c = c + 6'(v[i]);
    return c;
  endfunction

  localparam int PELLET_TOTAL = FULL_ROWS * int'(popcount(ROW_FULL)) +
                                SIDE_ROWS * int'(popcount(ROW_SIDE));

endpackage

// File: rtl/pellet_layout_rom.sv
// Combinational maze layout: one 32-bit pellet mask per row; the border rows
// (0 and 31) and border columns (0 and 31) are outside the maze and always 0.
module pellet_layout_rom
  import pellet_map_pkg::*;
(
  input  logic [4:0]       row,
  output logic [MAP_W-1:0] mask
);

  always_comb begin
    // NOTE: default assigned first so every path drives mask and no latch is inferred.
    mask = '0;
    if (row != 5'd0 && row != 5'd31) begin
      mask = (row[1:0] == 2'b00) ? ROW_FULL : ROW_SIDE;
    end
  end

endmodule

// File: rtl/pellet_map.sv
// Pellet bitmap for the maze: loads the layout, serves renderer reads, handles
// eat requests and tracks pellets left. PELLET_AUTO_REFILL_EN: CLEAR goes straight to FILL.
module pellet_map
  import pellet_map_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       xout,
  input  logic [4:0]       yout,
  output logic             din,
  input  logic             eat_req,
  input  logic [4:0]       eat_x,
  input  logic [4:0]       eat_y,
  output logic             eat_ack,
  output logic             eat_hit,
  output logic             eat_power,
  input  logic             refill_req,
  output logic             busy,
  output logic [CNT_W-1:0] pellets_left,
  output logic             level_clear
);

  state_t           state, state_next;
  logic [4:0]       row_ptr;
  logic [MAP_W-1:0] rom_row;
  logic [MAP_W-1:0] map [MAP_H];

  logic eat_go;
  logic eat_hit_now;
  logic eat_power_now;

  pellet_layout_rom u_rom (
    .row  (row_ptr),
    .mask (rom_row)
  );

  // The cycle right after an ack is never accepted, so a held request is
  // served at most once every two cycles.
  assign eat_go        = (state == ST_READY) && eat_req && !eat_ack && !refill_req;
  assign eat_hit_now   = eat_go && map[eat_y][eat_x];
  assign eat_power_now = eat_hit_now &&
                         (eat_x == PWR_X0 || eat_x == PWR_X1) &&
                         (eat_y == PWR_Y0 || eat_y == PWR_Y1);

  assign busy        = (state == ST_FILL);
  assign level_clear = (state == ST_CLEAR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (refill_req) begin
      state_next = ST_FILL;
    end else begin
      case (state)
        ST_FILL:  if (row_ptr == 5'(MAP_H - 1)) state_next = ST_READY;
        ST_READY: if (eat_hit_now && pellets_left == CNT_W'(1)) state_next = ST_CLEAR;
`ifdef PELLET_AUTO_REFILL_EN
        ST_CLEAR: state_next = ST_FILL;
`else
        ST_CLEAR: state_next = ST_READY;
`endif
        default:  state_next = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_ptr      <= '0;
      pellets_left <= '0;
      din          <= 1'b0;
      eat_ack      <= 1'b0;
      eat_hit      <= 1'b0;
      eat_power    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every read below sees pre-edge state
      // (a renderer read of a cell being eaten returns the old bit).
      eat_ack   <= eat_go;
      eat_hit   <= eat_hit_now;
      eat_power <= eat_power_now;
      din       <= (state_next == ST_FILL) ? 1'b0 : map[yout][xout];

      if (state == ST_FILL && state_next == ST_FILL && !refill_req) row_ptr <= row_ptr + 5'd1;
      else                                                         row_ptr <= '0;

      if (refill_req)             pellets_left <= '0;
      else if (state == ST_FILL)  pellets_left <= pellets_left + {4'b0, popcount(rom_row)};
      else if (eat_hit_now)       pellets_left <= pellets_left - CNT_W'(1);
    end
  end

  // NOTE: the map has no reset; its contents are meaningless until FILL rewrites every row.
  always_ff @(posedge clk) begin
    if (state == ST_FILL)  map[row_ptr] <= rom_row;
    else if (eat_hit_now)  map[eat_y][eat_x] <= 1'b0;
  end

endmodule

// File: tb/tb_pellet_map.sv
// Directed self-checking bench for pellet_map; expected values come from an
// independent maze description and a shadow copy of the map kept by the bench.
module tb_pellet_map;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] xout, yout, eat_x, eat_y;
  logic       din, eat_req, eat_ack, eat_hit, eat_power, refill_req, busy, level_clear;
  logic [9:0] pellets_left;

  int errors = 0;
  int checks = 0;
  bit exp_map [32][32];
  int exp_left;
  int model_total;

  always #5 clk = ~clk;

  pellet_map dut (
    .clk          (clk),
    .reset        (reset),
    .xout         (xout),
    .yout         (yout),
    .din          (din),
    .eat_req      (eat_req),
    .eat_x        (eat_x),
    .eat_y        (eat_y),
    .eat_ack      (eat_ack),
    .eat_hit      (eat_hit),
    .eat_power    (eat_power),
    .refill_req   (refill_req),
    .busy         (busy),
    .pellets_left (pellets_left),
    .level_clear  (level_clear)
  );

  // Maze: inner area 1..30 x 1..30; every 4th row open, otherwise side lanes only.
  function automatic bit model_pellet(int x, int y);
    if (x < 1 || x > 30 || y < 1 || y > 30) return 1'b0;
    return (y % 4 == 0) || x == 1 || x == 2 || x == 27 || x == 30;
  endfunction

  task automatic model_refill();
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) exp_map[y][x] = model_pellet(x, y);
    exp_left = model_total;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_cycles(output int n, output bit ack_seen);
    n = 0;
    ack_seen = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (eat_ack === 1'b1) ack_seen = 1'b1;
      if (busy === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_eat(input logic [4:0] x, input logic [4:0] y, output bit acked, output int lat,
                        output logic hit, output logic pwr, output logic lc, output logic [9:0] left);
    eat_x = x; eat_y = y; eat_req = 1'b1;
    acked = 1'b0; lat = 0; hit = 1'b0; pwr = 1'b0; lc = 1'b0; left = '0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (eat_ack === 1'b1) begin
        acked = 1'b1; lat = i; hit = eat_hit; pwr = eat_power; lc = level_clear; left = pellets_left;
        break;
      end
    end
    eat_req = 1'b0;
  endtask

  task automatic test_reset();
    int n; bit ack_seen;
    reset = 1'b1; eat_req = 1'b0; refill_req = 1'b0;
    eat_x = '0; eat_y = '0; xout = '0; yout = '0;
    tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if (pellets_left !== 10'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pellets_left); end
    checks++; if ({din, eat_ack, eat_hit, eat_power, level_clear} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: din/ack/hit/pwr/clr got %b want 00000", {din, eat_ack, eat_hit, eat_power, level_clear});
    end
    reset = 1'b0;
    fill_cycles(n, ack_seen);
    checks++; if (n != 32) begin errors++; $display("FAIL reset_fill_len: got %0d cycles want 32", n); end
    checks++; if (pellets_left !== 10'(model_total)) begin errors++; $display("FAIL reset_total: got %0d want %0d", pellets_left, model_total); end
    model_refill();
  endtask

  task automatic test_din();
    int cells [4][2] = '{'{1, 1}, '{0, 0}, '{5, 4}, '{5, 5}};
    for (int i = 0; i < 4; i++) begin
      xout = 5'(cells[i][0]); yout = 5'(cells[i][1]);
      tick();
      checks++; if (din !== exp_map[cells[i][1]][cells[i][0]]) begin
        errors++; $display("FAIL din_read(%0d,%0d): got %b want %b", cells[i][0], cells[i][1], din, exp_map[cells[i][1]][cells[i][0]]);
      end
    end
  endtask

  task automatic test_power();
    bit acked; int lat; logic hit, pwr, lc; logic [9:0] left;
    do_eat(5'd2, 5'd4, acked, lat, hit, pwr, lc, left);
    exp_left--; exp_map[4][2] = 1'b0;
    checks++; if (!acked || lat != 1) begin errors++; $display("FAIL power_ack: acked=%b latency=%0d want 1 cycle", acked, lat); end
    checks++; if ({hit, pwr} !== 2'b11) begin errors++; $display("FAIL power_flags: hit/pwr got %b want 11", {hit, pwr}); end
    checks++; if (left !== 10'(exp_left)) begin errors++; $display("FAIL power_count: got %0d want %0d", left, exp_left); end
    tick();
    do_eat(5'd2, 5'd4, acked, lat, hit, pwr, lc, left);
    checks++; if (!acked || {hit, pwr} !== 2'b00) begin errors++; $display("FAIL power_repeat: acked=%b hit/pwr got %b want 00", acked, {hit, pwr}); end
    checks++; if (left !== 10'(exp_left)) begin errors++; $display("FAIL power_repeat_count: got %0d want %0d", left, exp_left); end
    tick();
    do_eat(5'd27, 5'd5, acked, lat, hit, pwr, lc, left);
    exp_left--; exp_map[5][27] = 1'b0;
    checks++; if (!acked || {hit, pwr} !== 2'b10) begin errors++; $display("FAIL power_row_miss(27,5): hit/pwr got %b want 10", {hit, pwr}); end
    tick();
    do_eat(5'd27, 5'd24, acked, lat, hit, pwr, lc, left);
    exp_left--; exp_map[24][27] = 1'b0;
    checks++; if (!acked || {hit, pwr} !== 2'b11) begin errors++; $display("FAIL power_corner(27,24): hit/pwr got %b want 11", {hit, pwr}); end
    tick();
  endtask

  task automatic test_ordinary();
    bit acked; int lat; logic hit, pwr, lc; logic [9:0] left;
    do_eat(5'd1, 5'd1, acked, lat, hit, pwr, lc, left);
    exp_left--; exp_map[1][1] = 1'b0;
    checks++; if (!acked || {hit, pwr} !== 2'b10) begin errors++; $display("FAIL ordinary_flags: hit/pwr got %b want 10", {hit, pwr}); end
    checks++; if (left !== 10'(exp_left)) begin errors++; $display("FAIL ordinary_count: got %0d want %0d", left, exp_left); end
    xout = 5'd1; yout = 5'd1;
    tick(); tick();
    checks++; if (din !== 1'b0) begin errors++; $display("FAIL ordinary_din_after: got %b want 0", din); end
    xout = 5'd2;
    tick();
    checks++; if (din !== 1'b1) begin errors++; $display("FAIL ordinary_neighbour: got %b want 1", din); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] acks;
    logic [3:0] hits;
    eat_x = 5'd30; eat_y = 5'd1; eat_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks[i] = eat_ack; hits[i] = eat_hit;
    end
    eat_req = 1'b0;
    exp_left--; exp_map[1][30] = 1'b0;
    checks++; if (acks !== 4'b0101) begin errors++; $display("FAIL b2b_ack_pattern: got %b want 0101 (bit0 first)", acks); end
    checks++; if ({hits[2], hits[0]} !== 2'b01) begin errors++; $display("FAIL b2b_hits: second/first got %b want 01", {hits[2], hits[0]}); end
    checks++; if (pellets_left !== 10'(exp_left)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", pellets_left, exp_left); end
    tick();
  endtask

  task automatic test_same_cycle_read();
    xout = 5'd3; yout = 5'd4;
    eat_x = 5'd3; eat_y = 5'd4; eat_req = 1'b1;
    tick();
    eat_req = 1'b0;
    exp_left--; exp_map[4][3] = 1'b0;
    checks++; if ({eat_ack, eat_hit, din} !== 3'b111) begin
      errors++; $display("FAIL same_cycle_pre_eat: ack/hit/din got %b want 111", {eat_ack, eat_hit, din});
    end
    tick();
    checks++; if (din !== 1'b0) begin errors++; $display("FAIL same_cycle_post_eat: got %b want 0", din); end
  endtask

  task automatic test_refill_priority();
    bit acked; int lat; logic hit, pwr, lc; logic [9:0] left; int n; bit ack_seen;
    do_eat(5'd1, 5'd2, acked, lat, hit, pwr, lc, left);
    checks++; if (!acked || hit !== 1'b1) begin errors++; $display("FAIL refill_pre_eat: acked=%b hit=%b want 1 1", acked, hit); end
    tick();
    refill_req = 1'b1; eat_x = 5'd1; eat_y = 5'd2; eat_req = 1'b1;
    tick();
    refill_req = 1'b0;
    checks++; if ({busy, eat_ack} !== 2'b10 || pellets_left !== 10'd0) begin
      errors++; $display("FAIL refill_start: busy/ack got %b count %0d want 10 count 0", {busy, eat_ack}, pellets_left);
    end
    fill_cycles(n, ack_seen);
    checks++; if (n != 32 || ack_seen) begin errors++; $display("FAIL refill_fill: got %0d cycles ack_seen=%b want 32 0", n, ack_seen); end
    model_refill();
    checks++; if (pellets_left !== 10'(exp_left)) begin errors++; $display("FAIL refill_total: got %0d want %0d", pellets_left, exp_left); end
    tick();
    eat_req = 1'b0;
    exp_left--; exp_map[2][1] = 1'b0;
    checks++; if ({eat_ack, eat_hit} !== 2'b11 || pellets_left !== 10'(exp_left)) begin
      errors++; $display("FAIL refill_pending_eat: ack/hit got %b count %0d want 11 count %0d", {eat_ack, eat_hit}, pellets_left, exp_left);
    end
    tick();
  endtask

  task automatic test_clear();
    bit acked; int lat; logic hit, pwr, lc; logic [9:0] left; int n; bit ack_seen;
    int remaining; int bad;
    remaining = exp_left; bad = 0;
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        if (exp_map[y][x]) begin
          do_eat(5'(x), 5'(y), acked, lat, hit, pwr, lc, left);
          exp_map[y][x] = 1'b0; exp_left--; remaining--;
          if (!acked || hit !== 1'b1 || left !== 10'(exp_left)) bad++;
          if (remaining > 0) begin
            if (lc !== 1'b0) bad++;
            tick();
          end
        end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL clear_sweep: %0d bad acks, want 0", bad); end
    checks++; if (lc !== 1'b1 || left !== 10'd0) begin errors++; $display("FAIL clear_final: level_clear=%b count=%0d want 1 0", lc, left); end
    tick();
    checks++; if (level_clear !== 1'b0) begin errors++; $display("FAIL clear_pulse_len: got %b want 0", level_clear); end
`ifdef PELLET_AUTO_REFILL_EN
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clear_auto_busy: got %b want 1", busy); end
`else
    checks++; if (busy !== 1'b0 || pellets_left !== 10'd0) begin
      errors++; $display("FAIL clear_idle: busy=%b count=%0d want 0 0", busy, pellets_left);
    end
    do_eat(5'd1, 5'd1, acked, lat, hit, pwr, lc, left);
    checks++; if (!acked || hit !== 1'b0 || left !== 10'd0) begin
      errors++; $display("FAIL clear_empty_eat: acked=%b hit=%b count=%0d want 1 0 0", acked, hit, left);
    end
    tick();
    refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
`endif
    fill_cycles(n, ack_seen);
    model_refill();
    checks++; if (n != 32 || pellets_left !== 10'(exp_left)) begin
      errors++; $display("FAIL clear_next_level: %0d cycles count %0d want 32 %0d", n, pellets_left, exp_left);
    end
  endtask

  task automatic test_reset_mid_fill();
    int n; bit ack_seen; int part;
    part = 0;
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 32; x++) part += int'(model_pellet(x, y));
    xout = 5'd1; yout = 5'd1;
    refill_req = 1'b1;
    tick();
    refill_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (pellets_left !== 10'(part) || din !== 1'b0) begin
      errors++; $display("FAIL midfill_progress: count %0d din %b want %0d 0", pellets_left, din, part);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (pellets_left !== 10'd0 || {busy, din, eat_ack, eat_hit, eat_power, level_clear} !== 6'b100000) begin
      errors++; $display("FAIL midfill_reset: count %0d busy/din/ack/hit/pwr/clr %b want 0 100000",
                         pellets_left, {busy, din, eat_ack, eat_hit, eat_power, level_clear});
    end
    tick();
    reset = 1'b0;
    fill_cycles(n, ack_seen);
    model_refill();
    checks++; if (n != 32 || pellets_left !== 10'(exp_left)) begin
      errors++; $display("FAIL midfill_refill: %0d cycles count %0d want 32 %0d", n, pellets_left, exp_left);
    end
  endtask

  initial begin
    model_total = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) model_total += int'(model_pellet(x, y));
    test_reset();
    test_din();
    test_power();
    test_ordinary();
    test_back_to_back();
    test_same_cycle_read();
    test_refill_priority();
    test_clear();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
